// File: rtl/barret_1607_arbiter.sv
// barret_1607_arbiter: shares one combinational mod-1607 reducer between NREQ requesters.
// Round-robin arbitration by default; define BARRET_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
// Ports: clk, rst (async, active-high); req_valid/req_data/req_ready per requester (21-bit operand i at
// req_data[21*i +: 21]); res_valid/res_data/res_id/res_ready result handshake; done_count counts deliveries.

module barret_for_1607 (
  input  logic [20:0] x,
  output logic [10:0] r
);
  logic [10:0] q;
  logic [20:0] t;
  // m = floor(2^22/1607) = 2610 underestimates the quotient by at most 1 for any 21-bit x,
  // so a single conditional subtract finishes the reduction.
  assign q = 11'((33'(x) * 33'd2610) >> 22);
  assign t = x - 21'(q) * 21'd1607;
  assign r = t >= 21'd1607 ? 11'(t - 21'd1607) : t[10:0];
endmodule

module barret_1607_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*21-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [10:0]       res_data,
  output logic [2:0]        res_id,
  input  logic              res_ready,
  output logic [15:0]       done_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic run, take;
  logic [2:0] grant;
  logic [20:0] operand;
  logic [10:0] residue;
  assign res_valid = state == FULL;
  assign take = !res_valid || res_ready;
`ifdef BARRET_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[i]) grant = 3'(i);
  end
`else
  logic [2:0] last;
  logic [NREQ-1:0] sh;
  // Scan from farthest to nearest after last so the nearest pending requester wins.
  always_comb begin
    grant = '0;
    sh = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sh = req_valid >> ((int'(last) + k) % NREQ);
      if (sh[0]) grant = 3'((int'(last) + k) % NREQ);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 3'(NREQ - 1);
    else if (|req_ready) last <= grant;
`endif
  // run is cleared asynchronously by rst, keeping req_ready low until the first edge after release.
  assign req_ready = (run && take && |req_valid) ? NREQ'(1) << grant : '0;
  assign operand = 21'(req_data >> (21 * grant));
  barret_for_1607 u_red (.x(operand), .r(residue));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= EMPTY;
      res_data   <= '0;
      res_id     <= '0;
      done_count <= '0;
      run        <= 1'b0;
    end else begin
      run <= 1'b1;
      if (|req_ready) begin
        state    <= FULL;
        res_data <= residue;
        res_id   <= grant;
      end else if (res_ready) state <= EMPTY;
      if (res_valid && res_ready) done_count <= done_count + 16'd1;
    end
endmodule

// File: tb/tb_barret_1607_arbiter.sv
// tb_barret_1607_arbiter: randomized and directed checks of barret_1607_arbiter against a behavioural model.
module tb_barret_1607_arbiter;
  localparam int NREQ = 4;
  logic clk = 1'b0, rst, res_ready;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*21-1:0] req_data;
  logic res_valid;
  logic [10:0] res_data;
  logic [2:0] res_id;
  logic [15:0] done_count;
  int checks = 0, errors = 0;
  bit m_valid, m_run;
  int m_data, m_id, m_last;
  logic [15:0] m_done;

  always #5 clk = ~clk;

  barret_1607_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .done_count(done_count)
  );

  function automatic int operand(int i);
    return int'(21'(req_data >> (21 * i)));
  endfunction

  function automatic int pick();
    if (!m_run || (m_valid && !res_ready) || req_valid == '0) return -1;
`ifdef BARRET_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (req_valid[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (req_valid[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g = pick();
    return g < 0 ? '0 : NREQ'(1) << g;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_run = 0; m_data = 0; m_id = 0; m_last = NREQ - 1; m_done = 0;
  endtask

  task automatic model_edge();
    int g = pick();
    bit dl = m_valid && res_ready;
    if (g >= 0) begin
      m_valid = 1; m_data = operand(g) % 1607; m_id = g; m_last = g;
    end else if (res_ready) m_valid = 0;
    if (dl) m_done = m_done + 16'd1;
    m_run = 1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req_valid = '0; req_data = '0; res_ready = 1;
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    #1 tick();
  endtask

  task automatic test_reset();
    rst = 1; req_valid = '1; req_data = '0; res_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, res_valid, res_data, res_id, done_count} !== '0) begin
      errors++; $display("FAIL reset_state got %h want 0", {req_ready, res_valid, res_data, res_id, done_count});
    end
    rst = 0;
    #1 checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_release_ready got %b want 0", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_data = '0; req_data[62:42] = 21'd5000; res_ready = 1;
    #1 checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    #1 checks++;
    if ({res_valid, res_data, res_id, done_count} !== {1'b1, 11'd179, 3'd2, 16'd0}) begin
      errors++; $display("FAIL single_result got v%b d%0d id%0d dc%0d want v1 d179 id2 dc0", res_valid, res_data, res_id, done_count);
    end
    tick();
    #1 checks++;
    if (done_count !== 16'd1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got dc%0d v%b want dc1 v0", done_count, res_valid);
    end
  endtask

  task automatic test_boundary();
    int v[5] = '{0, 1606, 1607, 3214, 2097151};
    int e[5] = '{0, 1606, 0, 0, 16};
    res_ready = 1;
    for (int i = 0; i <= 5; i++) begin
      req_valid = i < 5 ? 4'b0001 : 4'b0000;
      req_data = '0;
      if (i < 5) req_data[20:0] = 21'(v[i]);
      #1;
      if (i < 5) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL boundary_ready %0d got %b want 0001", i, req_ready); end
      end
      if (i > 0) begin
        checks++;
        if (res_valid !== 1'b1 || res_data !== 11'(e[i-1]) || res_id !== 3'd0) begin
          errors++; $display("FAIL boundary_res %0d got v%b d%0d id%0d want v1 d%0d id0", i, res_valid, res_data, res_id, e[i-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int g, prev = 0;
    do_reset();
    req_valid = '1;
    for (int r = 0; r < NREQ; r++) req_data[21*r +: 21] = 21'($urandom);
    for (int i = 0; i < 8; i++) begin
`ifdef BARRET_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = i % NREQ;
`endif
      #1 checks++;
      if (req_ready !== NREQ'(1) << g) begin errors++; $display("FAIL rr_grant %0d got %b want %0d", i, req_ready, g); end
      checks++;
      if ({res_valid, res_data, res_id, done_count} !== {m_valid, 11'(m_data), 3'(m_id), m_done}) begin
        errors++; $display("FAIL rr_model %0d got %h want %h", i, {res_valid, res_data, res_id, done_count}, {m_valid, 11'(m_data), 3'(m_id), m_done});
      end
      if (i > 0) begin
        checks++;
        if (res_id !== 3'(prev)) begin errors++; $display("FAIL rr_id %0d got %0d want %0d", i, res_id, prev); end
      end
      prev = g;
      tick();
      req_data[21*g +: 21] = 21'($urandom);
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] d;
    logic [2:0] id;
    logic [15:0] dc;
    int nxt;
    res_ready = 0;
    #1 d = res_data; id = res_id; dc = done_count;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_ready !== '0 || res_valid !== 1'b1 || res_data !== d || res_id !== id || done_count !== dc) begin
        errors++; $display("FAIL bp_hold %0d got rdy%b v%b d%0d id%0d dc%0d want rdy0 v1 d%0d id%0d dc%0d",
                           i, req_ready, res_valid, res_data, res_id, done_count, d, id, dc);
      end
      tick();
      #1;
    end
    res_ready = 1;
`ifdef BARRET_ARB_FIXED_PRIO_EN
    nxt = 0;
`else
    nxt = (int'(id) + 1) % NREQ;
`endif
    #1 checks++;
    if (req_ready !== NREQ'(1) << nxt) begin errors++; $display("FAIL bp_resume got %b want %0d", req_ready, nxt); end
    tick();
    checks++;
    if (res_id !== 3'(nxt) || done_count !== dc + 16'd1) begin
      errors++; $display("FAIL bp_after got id%0d dc%0d want id%0d dc%0d", res_id, done_count, nxt, dc + 16'd1);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] nv, granted;
    granted = '0;
    for (int c = 0; c < 400; c++) begin
      nv = NREQ'($urandom);
      for (int r = 0; r < NREQ; r++)
        if (!req_valid[r] || granted[r] || !nv[r]) req_data[21*r +: 21] = 21'($urandom);
      req_valid = nv;
      res_ready = ($urandom_range(0, 3) != 0);
      #1 checks++;
      if ({req_ready, res_valid, res_data, res_id, done_count} !== {exp_ready(), m_valid, 11'(m_data), 3'(m_id), m_done}) begin
        errors++; $display("FAIL random_model %0d got %h want %h", c, {req_ready, res_valid, res_data, res_id, done_count},
                           {exp_ready(), m_valid, 11'(m_data), 3'(m_id), m_done});
      end
      granted = req_ready;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    req_valid = '1; res_ready = 1;
    tick();
    #1 checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got v%b want v1", res_valid); end
    res_ready = 0;
    #2 rst = 1;
    #1 checks++;
    if ({req_ready, res_valid, res_data, res_id, done_count} !== '0) begin
      errors++; $display("FAIL mid_async got %h want 0", {req_ready, res_valid, res_data, res_id, done_count});
    end
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    res_ready = 1;
    #1 checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL mid_release got %b want 0", req_ready); end
    tick();
    #1 checks++;
    if (req_ready !== 4'b0001 || req_ready !== exp_ready()) begin
      errors++; $display("FAIL mid_first got %b want 0001", req_ready);
    end
    tick();
    checks++;
    if (res_id !== 3'd0 || res_valid !== 1'b1) begin errors++; $display("FAIL mid_id got id%0d v%b want id0 v1", res_id, res_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    res_ready = 1;
    for (int i = 0; i <= 70001; i++) begin
      req_valid = i <= 70000 ? 4'b0001 : 4'b0000;
      req_data = '0;
      req_data[20:0] = 21'(i % 2097152);
      #1;
      if (i >= 1) begin
        checks++;
        if (res_valid !== 1'b1 || res_data !== 11'((i - 1) % 1607) || done_count !== 16'(i - 1)) begin
          errors++; $display("FAIL wrap_stream %0d got v%b d%0d dc%0d want v1 d%0d dc%0d",
                             i, res_valid, res_data, done_count, (i - 1) % 1607, 16'(i - 1));
        end
      end
      if (i == 65537) begin
        checks++;
        if (done_count !== 16'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", done_count); end
      end
      tick();
    end
    #1 checks++;
    if (done_count !== 16'd4465 || res_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_final got dc%0d v%b want dc4465 v0", done_count, res_valid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
